// File: rtl/dcm_pkg.sv
// rtl/dcm_pkg.sv - shared widths, FSM state type and selection step helper for dcm_ctrl
package dcm_pkg;

    localparam int PROG_W = 3;
    localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_WAIT,
        ST_ERROR
    } dcm_state_t;

    // Saturating step; simultaneous up and down cancel out.
    function automatic logic [PROG_W-1:0] sel_step(
        input logic [PROG_W-1:0] cur,
        input logic              up,
        input logic              down
    );
        if (up && !down && cur != PROG_MAX) return cur + PROG_W'(1);
        if (down && !up && cur != '0) return cur - PROG_W'(1);
        return cur;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, level debouncer and rising-edge pulse for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                pulse <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dcm_ctrl.sv
// rtl/dcm_ctrl.sv - button-driven frequency selection and acknowledged update of a dcm
module dcm_ctrl
    import dcm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACK_TIMEOUT     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_apply,
    input  logic [PROG_W-1:0] prog_out,
    output logic [PROG_W-1:0] prog_in,
    output logic              update,
    output logic [PROG_W-1:0] sel,
    output logic              busy,
    output logic              error
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    logic              up_p;
    logic              down_p;
    logic              apply_p;
    logic [PROG_W-1:0] sel_next;
    logic [TW-1:0]     wait_cnt;
    dcm_state_t        state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn(btn_up), .pulse(up_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst(rst), .btn(btn_down), .pulse(down_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_apply (
        .clk(clk), .rst(rst), .btn(btn_apply), .pulse(apply_p)
    );

    assign sel_next = sel_step(sel, up_p, down_p);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            sel      <= '0;
            prog_in  <= '0;
            update   <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            update <= 1'b0;
            case (state)
                ST_IDLE, ST_ERROR: begin
                    // Apply commits the post-step selection; ERROR always retries.
                    sel <= sel_next;
                    if (apply_p && (state == ST_ERROR || sel_next != prog_out)) begin
                        state <= ST_UPDATE;
                        busy  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    prog_in  <= sel;
                    update   <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    if (prog_out == prog_in) begin
                        state <= ST_IDLE;
                        error <= 1'b0;
                        busy  <= 1'b0;
                    end else if (wait_cnt == TO_LAST) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcm_ctrl.sv
// tb/tb_dcm_ctrl.sv - scoreboard bench for dcm_ctrl with an echoing dcm model
module tb_dcm_ctrl;

    localparam int DEB = 4;
    localparam int ACK = 8;
    localparam int GAP = DEB + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_apply = 1'b0;
    logic [2:0] prog_out = 3'd0;
    logic [2:0] prog_in;
    logic       update;
    logic [2:0] sel;
    logic       busy;
    logic       error;

    logic       frozen = 1'b0;
    logic [2:0] pend_val = 3'd0;
    int         pend_cnt = 0;

    int         total = 0;
    int         bad = 0;
    logic [2:0] exp_q[$];

    dcm_ctrl #(.DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .btn_apply(btn_apply), .prog_out(prog_out), .prog_in(prog_in),
        .update(update), .sel(sel), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // dcm model: echoes latched prog_in onto prog_out three cycles after update
    always @(posedge clk) begin
        if (update && !frozen) begin
            pend_val <= prog_in;
            pend_cnt <= 3;
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
            if (pend_cnt == 1) prog_out <= pend_val;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic prev_update;
        logic [2:0] exp_v;
        prev_update = 1'b0;
        forever begin
            @(negedge clk);
            if (update) begin
                check("update_not_consecutive", int'(prev_update), 0);
                check("busy_during_update", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    check("update_expected", exp_q.size(), 1);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("update_prog_in", int'(prog_in), int'(exp_v));
                end
            end
            prev_update = update;
        end
    endtask

    // which: 0 up, 1 down, 2 up+down together
    task automatic press(input int which);
        if (which == 0 || which == 2) btn_up = 1'b1;
        if (which == 1 || which == 2) btn_down = 1'b1;
        repeat (GAP) @(posedge clk);
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic apply_press(output int busy_cycles);
        btn_apply = 1'b1;
        busy_cycles = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
        end
        btn_apply = 1'b0;
        repeat (GAP) @(posedge clk);
    endtask

    initial begin
        int bc;
        int seen;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_sel", int'(sel), 0);
        check("reset_prog_in", int'(prog_in), 0);
        check("reset_update", int'(update), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_error", int'(error), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        apply_press(bc);
        check("apply_equal_no_busy", bc, 0);

        for (int i = 0; i < 3; i++) press(0);
        #1;
        check("three_ups_sel", int'(sel), 3);
        exp_q.push_back(3'd3);
        apply_press(bc);
        check("apply3_busy_seen", int'(bc > 0), 1);
        check("apply3_busy_cleared", int'(busy), 0);
        check("apply3_prog_out", int'(prog_out), 3);
        check("apply3_error", int'(error), 0);

        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            repeat (2) @(posedge clk);
        end
        btn_up = 1'b1;
        repeat (GAP) @(posedge clk);
        btn_up = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        check("bounce_single_inc", int'(sel), 4);

        for (int i = 0; i < 4; i++) press(0);
        #1;
        check("sat_high", int'(sel), 7);
        for (int i = 0; i < 8; i++) press(1);
        #1;
        check("sat_low", int'(sel), 0);
        press(0);
        press(0);
        press(2);
        #1;
        check("up_down_cancel", int'(sel), 2);

        for (int i = 0; i < 3; i++) press(0);
        frozen = 1'b1;
        exp_q.push_back(3'd5);
        apply_press(bc);
        check("timeout_busy_cycles", bc, 1 + ACK);
        check("timeout_error", int'(error), 1);
        check("timeout_prog_in", int'(prog_in), 5);
        frozen = 1'b0;
        exp_q.push_back(3'd5);
        apply_press(bc);
        check("retry_error_cleared", int'(error), 0);
        check("retry_prog_out", int'(prog_out), 5);

        press(0);
        exp_q.push_back(3'd6);
        btn_apply = 1'b1;
        seen = 0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (update) seen = 1;
        end
        check("reset_test_update_seen", seen, 1);
        btn_apply = 1'b0;
        btn_up = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_prog_in", int'(prog_in), 0);
        check("abort_update", int'(update), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_sel", int'(sel), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("held_btn_one_pulse", int'(sel), 1);
        check("abort_idle_busy", int'(busy), 0);
        btn_up = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
